// File: rtl/secded_pkg.sv
// Shared types and constants for the SECDED batch decoder: sequencer states,
// decode status codes and the Hamming positions that carry data bits.
package secded_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        CAP   = 3'd3,
        WR_HI = 3'd4,
        WR_LO = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_SINGLE = 2'b01;
    localparam logic [1:0] ST_DOUBLE = 2'b10;

    // Entry j is the codeword position of data bit d(j+1).
    localparam logic [10:0][3:0] DATA_POS = {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10,
                                             4'd9,  4'd7,  4'd6,  4'd5,  4'd3};

    function automatic logic [7:0] result_hi(input logic [1:0] st, input logic [10:0] d);
        return {st, 3'b000, d[10:8]};
    endfunction

endpackage

// File: rtl/secded_dec16.sv
// Combinational 16-bit Hamming SECDED decoder: corrects one error, flags two,
// and returns the 11 data bits with a two-bit status.
module secded_dec16
    import secded_pkg::*;
(
    input  logic [15:0] cw_i,
    output logic [10:0] data_o,
    output logic [1:0]  status_o
);

    logic [3:0] syn_s;
    logic       par_s;

    // Syndrome, overall parity, classification and in-place correction of data bits.
    always_comb begin
        syn_s    = 4'd0;
        par_s    = ^cw_i;
        data_o   = 11'd0;
        status_o = ST_CLEAN;
        for (int k = 1; k < 16; k++) begin
            syn_s = syn_s ^ (cw_i[k] ? 4'(k) : 4'd0);
        end
        if (par_s) begin
            status_o = ST_SINGLE;
        end else if (syn_s != 4'd0) begin
            status_o = ST_DOUBLE;
        end else begin
            status_o = ST_CLEAN;
        end
        // Only a single error is corrected; a zero syndrome points at p0, which carries no data.
        for (int j = 0; j < 11; j++) begin
            data_o[j] = cw_i[DATA_POS[j]] ^ (par_s && (syn_s == DATA_POS[j]));
        end
    end

endmodule

// File: rtl/secded_batch_ctrl.sv
// Data-memory master that decodes a batch of SECDED codewords from SRC_BASE and
// writes status-tagged results to DST_BASE, keeping per-outcome counters.
module secded_batch_ctrl
    import secded_pkg::*;
#(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 30,
    parameter int unsigned DST_BASE = 0,
    parameter int unsigned AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] dm_addr,
    output logic          dm_we,
    output logic [7:0]    dm_wdata,
    input  logic [7:0]    dm_rdata,
    output logic [3:0]    n_clean,
    output logic [3:0]    n_single,
    output logic [3:0]    n_double
);

    localparam int unsigned   IW       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [7:0]    lo_q;
    logic [10:0]   data_q;
    logic [1:0]    status_q;
    logic          busy_q;
    logic          done_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic [3:0]    n_clean_q;
    logic [3:0]    n_single_q;
    logic [3:0]    n_double_q;
    logic [10:0]   dec_data_s;
    logic [1:0]    dec_status_s;

    function automatic logic [AW-1:0] addr_of(input int unsigned base,
                                              input logic [IW-1:0] idx,
                                              input logic hi);
        return AW'(base + 32'd2 * 32'(idx) + 32'(hi));
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'd15) ? c : c + 4'd1;
    endfunction

    assign idx_d = idx_q + IW'(1);

    // The high byte arrives on dm_rdata during CAP, so decode sees the full word there.
    secded_dec16 u_dec (
        .cw_i     ({dm_rdata, lo_q}),
        .data_o   (dec_data_s),
        .status_o (dec_status_s)
    );

    // Sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            lo_q       <= 8'd0;
            data_q     <= 11'd0;
            status_q   <= ST_CLEAN;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'd0;
            n_clean_q  <= 4'd0;
            n_single_q <= 4'd0;
            n_double_q <= 4'd0;
        end else begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RD_LO;
                        idx_q      <= '0;
                        n_clean_q  <= 4'd0;
                        n_single_q <= 4'd0;
                        n_double_q <= 4'd0;
                        busy_q     <= 1'b1;
                        addr_q     <= addr_of(SRC_BASE, '0, 1'b0);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_LO: begin
                    state_q <= RD_HI;
                    addr_q  <= addr_of(SRC_BASE, idx_q, 1'b1);
                end
                RD_HI: begin
                    lo_q    <= dm_rdata;
                    state_q <= CAP;
                end
                CAP: begin
                    data_q   <= dec_data_s;
                    status_q <= dec_status_s;
                    we_q     <= 1'b1;
                    addr_q   <= addr_of(DST_BASE, idx_q, 1'b1);
                    wdata_q  <= result_hi(dec_status_s, dec_data_s);
                    state_q  <= WR_HI;
                end
                WR_HI: begin
                    we_q    <= 1'b1;
                    addr_q  <= addr_of(DST_BASE, idx_q, 1'b0);
                    wdata_q <= data_q[7:0];
                    state_q <= WR_LO;
                    case (status_q)
                        ST_CLEAN:  n_clean_q  <= sat_inc(n_clean_q);
                        ST_SINGLE: n_single_q <= sat_inc(n_single_q);
                        ST_DOUBLE: n_double_q <= sat_inc(n_double_q);
                        default:   n_clean_q  <= n_clean_q;
                    endcase
                end
                WR_LO: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_d;
                        addr_q  <= addr_of(SRC_BASE, idx_d, 1'b0);
                        state_q <= RD_LO;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dm_addr  = addr_q;
    assign dm_we    = we_q;
    assign dm_wdata = wdata_q;
    assign n_clean  = n_clean_q;
    assign n_single = n_single_q;
    assign n_double = n_double_q;

endmodule

// File: tb/tb_secded_batch_ctrl.sv
// Bench for secded_batch_ctrl: behavioural memory, codewords built from random
// data with known flips, expectations derived from the construction.
module tb_secded_batch_ctrl;

    localparam int NMSG = 15;
    localparam int SRC  = 30;
    localparam int DST  = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] dm_addr;
    logic       dm_we;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata = 8'd0;
    logic [3:0] n_clean;
    logic [3:0] n_single;
    logic [3:0] n_double;

    logic [15:0] g_cw = 16'd0;
    logic [10:0] g_data;
    logic [1:0]  g_status;

    logic [7:0] src_mem [256];
    logic [7:0] dst_mem [256];
    int         wr_cnt = 0;
    int         wr_bad = 0;

    logic [7:0] exp_hi [NMSG];
    logic [7:0] exp_lo [NMSG];
    int         exp_c  [4];

    int errors = 0;
    int checks = 0;

    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    secded_batch_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .dm_addr  (dm_addr),
        .dm_we    (dm_we),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .n_clean  (n_clean),
        .n_single (n_single),
        .n_double (n_double)
    );

    secded_dec16 u_gold (
        .cw_i     (g_cw),
        .data_o   (g_data),
        .status_o (g_status)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; writes land in a separate image that is audited.
    always @(posedge clk) begin
        dm_rdata <= src_mem[dm_addr];
        if (dm_we) begin
            dst_mem[dm_addr] <= dm_wdata;
            wr_cnt <= wr_cnt + 1;
            if (int'(dm_addr) < DST || int'(dm_addr) > DST + 2 * NMSG - 1) wr_bad <= wr_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        int          s;
        w = 16'd0;
        s = 0;
        for (int j = 0; j < 11; j++) begin
            if (d[j]) begin
                w[pos[j]] = 1'b1;
                s = s ^ pos[j];
            end
        end
        w[1] = s[0];
        w[2] = s[1];
        w[4] = s[2];
        w[8] = s[3];
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = w[pos[j]];
        return d;
    endfunction

    task automatic clear_exp();
        for (int k = 0; k < 4; k++) exp_c[k] = 0;
    endtask

    task automatic load_word(input int i, input logic [15:0] cw, input logic [1:0] st,
                             input logic [10:0] d);
        src_mem[SRC + 2 * i]     = cw[7:0];
        src_mem[SRC + 2 * i + 1] = cw[15:8];
        exp_hi[i] = {st, 3'b000, d[10:8]};
        exp_lo[i] = d[7:0];
        exp_c[st] = exp_c[st] + 1;
        g_cw = cw;
        #1;
        chk($sformatf("gold_status[%0d]", i), 32'(g_status), 32'(st));
        chk($sformatf("gold_data[%0d]", i), 32'(g_data), 32'(d));
    endtask

    // Random data word, one flip anywhere, and a distinct second flip one time in four.
    task automatic gen_rand(input int i);
        logic [10:0] d;
        logic [15:0] w;
        int          a;
        int          b;
        d = 11'($urandom_range(0, 2047));
        w = encode(d);
        a = int'($urandom_range(0, 15));
        w[a] = ~w[a];
        if ($urandom_range(0, 3) == 0) begin
            b = (a + int'($urandom_range(1, 15))) % 16;
            w[b] = ~w[b];
            load_word(i, w, 2'b10, extract(w));
        end else begin
            load_word(i, w, 2'b01, d);
        end
    endtask

    task automatic run_batch(input string tag);
        int cyc;
        int wr0;
        wr0 = wr_cnt;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
            if (done) break;
        end
        chk({tag, "_done_cycle"}, cyc, 32'd76);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, "_n_clean"}, 32'(n_clean), exp_c[0]);
        chk({tag, "_n_single"}, 32'(n_single), exp_c[1]);
        chk({tag, "_n_double"}, 32'(n_double), exp_c[2]);
        chk({tag, "_sum"}, 32'(n_clean) + 32'(n_single) + 32'(n_double), NMSG);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_hold"}, {30'd0, done, busy}, 32'd2);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {30'd0, done, busy}, 32'd0);
        for (int i = 0; i < NMSG; i++) begin
            chk($sformatf("%s_hi[%0d]", tag, i), 32'(dst_mem[DST + 2 * i + 1]), 32'(exp_hi[i]));
            chk($sformatf("%s_lo[%0d]", tag, i), 32'(dst_mem[DST + 2 * i]), 32'(exp_lo[i]));
        end
        chk({tag, "_writes"}, wr_cnt - wr0, 2 * NMSG);
        chk({tag, "_stray_writes"}, wr_bad, 32'd0);
    endtask

    initial begin
        int found;
        int wr_snap;
        for (int k = 0; k < 256; k++) src_mem[k] = 8'd0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(dm_we), 32'd0);
        chk("rst_addr", 32'(dm_addr), 32'd0);
        chk("rst_wdata", 32'(dm_wdata), 32'd0);
        chk("rst_counters", {20'd0, n_clean, n_single, n_double}, 32'd0);
        reset = 1'b0;

        // Batch A: directed corner words followed by random ones.
        clear_exp();
        load_word(0, 16'h0000, 2'b00, 11'h000);
        load_word(1, 16'h0008, 2'b01, 11'h000);
        load_word(2, 16'hFFFE, 2'b01, 11'h7FF);
        load_word(3, 16'hFFFF, 2'b00, 11'h7FF);
        load_word(4, 16'h0028, 2'b10, 11'h003);
        for (int i = 5; i < NMSG; i++) gen_rand(i);
        run_batch("dir");
        chk("dir_hi_0000", 32'(dst_mem[1]), 32'h00);
        chk("dir_hi_0008", 32'(dst_mem[3]), 32'h40);
        chk("dir_hi_FFFE", 32'(dst_mem[5]), 32'h47);
        chk("dir_hi_FFFF", 32'(dst_mem[7]), 32'h07);
        chk("dir_hi_0028", 32'(dst_mem[9]), 32'h80);
        chk("dir_lo_0028", 32'(dst_mem[8]), 32'h03);

        // Batch B: fully random.
        clear_exp();
        for (int i = 0; i < NMSG; i++) gen_rand(i);
        run_batch("rnd");

        // Batch C: reset while message 7 writes its high byte.
        clear_exp();
        for (int i = 0; i < NMSG; i++) gen_rand(i);
        found = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (dm_we && int'(dm_addr) == DST + 2 * 7 + 1) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid_found", found, 32'd1);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_state", {28'd0, busy, done, dm_we, |dm_addr}, 32'd0);
        chk("rst_mid_counters", {20'd0, n_clean, n_single, n_double}, 32'd0);
        wr_snap = wr_cnt;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_writes", wr_cnt, wr_snap);
        chk("rst_mid_idle", {30'd0, busy, done}, 32'd0);

        // Restart after the aborted batch.
        clear_exp();
        for (int i = 0; i < NMSG; i++) gen_rand(i);
        run_batch("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
